// File: rtl/mem_copy_master_if.sv
// Word-addressed data-memory port shared with the MEM stage: address, write data, write strobe, read data.
// Modport master drives the port while a copy runs; slave is the memory side.
interface mem_copy_master_if;
    logic [31:0] A;
    logic [31:0] wd;
    logic        memWriteM;
    logic [31:0] rd;

    modport master (output A, output wd, output memWriteM, input rd);
    modport slave  (input A, input wd, input memWriteM, output rd);
endinterface

// File: rtl/mem_copy_master.sv
// Copies len words src->dst over the data-memory port, 2+READ_LAT cycles/word (3+2*READ_LAT with MEM_COPY_VERIFY_EN read-back).
// No backpressure: the memory answers after exactly READ_LAT cycles; start outside IDLE is dropped.
module mem_copy_master #(
    parameter int          READ_LAT = 1,
    parameter logic [31:0] RAM_BASE = 32'd8500,
    parameter int          LEN_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       src_base,
    input  logic [31:0]       dst_base,
    input  logic [LEN_W-1:0]  len,
    mem_copy_master_if.master mem,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, RD, WT, WR, RV, VW, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] remain;
    logic [2:0]       wait_cnt;
    logic [32:0]      dst_last;
    logic             range_bad;

    // Carry out of the 33-bit sum means the last destination word wraps past 2^32-1.
    assign dst_last  = {1'b0, dst_base} + 33'(len) - 33'd1;
    assign range_bad = (dst_base < RAM_BASE) || dst_last[32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mem.A         <= '0;
            mem.wd        <= '0;
            mem.memWriteM <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            src_ptr       <= '0;
            dst_ptr       <= '0;
            remain        <= '0;
            wait_cnt      <= '0;
        end else begin
            done          <= 1'b0;
            mem.memWriteM <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src_base;
                        dst_ptr <= dst_base;
                        remain  <= len;
                        err     <= 1'b0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (range_bad) begin
                            err   <= 1'b1;
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RD;
                            busy  <= 1'b1;
                            mem.A <= src_base;
                        end
                    end
                end
                RD: begin
                    state    <= WT;
                    wait_cnt <= '0;
                end
                WT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        mem.wd        <= mem.rd;
                        mem.A         <= dst_ptr;
                        mem.memWriteM <= 1'b1;
                        state         <= WR;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                WR: begin
                    src_ptr <= src_ptr + 32'd1;
                    dst_ptr <= dst_ptr + 32'd1;
                    remain  <= remain - LEN_W'(1);
`ifdef MEM_COPY_VERIFY_EN
                    // A still holds the destination, so RV reads back the word just written.
                    state    <= RV;
`else
                    if (remain == LEN_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= RD;
                        mem.A <= src_ptr + 32'd1;
                    end
`endif
                end
`ifdef MEM_COPY_VERIFY_EN
                RV: begin
                    state    <= VW;
                    wait_cnt <= '0;
                end
                VW: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (mem.rd != mem.wd) begin
                            err   <= 1'b1;
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (remain == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RD;
                            mem.A <= src_ptr;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
`endif
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
